br_retire_resolve: RTL and testbench
====================================

Name: br_retire_resolve

Overview:
- Parametrised N-way retire-stage branch resolver.
- Scans the WIDTH oldest ROB entries and finds the oldest retire-ready branch whose executed outcome differs from its prediction.
- Gates which slots may retire, issues one registered mispredict/redirect pulse, and holds a flush window of FLUSH_CYCLES.
- Keeps saturating branch and mispredict counters; sits between the ROB head and fetch/rename recovery.

Parameters:
- WIDTH, 2: retire slots scanned per cycle; slot 0 is oldest; legal range 1..8.
- XLEN, 32: PC width.
- FLUSH_CYCLES, 2: cycles flush_busy stays high after detection, including the pulse cycle; must be >= 1.
- CNT_W, 32: width of each statistics counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- retire_rdy  in  WIDTH  per-slot ROB-entry-complete flag.
- is_branch  in  WIDTH  slot holds a branch.
- ex_take  in  WIDTH  executed taken.
- pred_take  in  WIDTH  predicted taken.
- ex_target  in  WIDTH*XLEN  executed target; slot i occupies bits [i*XLEN +: XLEN].
- pred_target  in  WIDTH*XLEN  predicted target, same packing.
- stat_clear  in  1  synchronous clear of both counters.
- retire_en  out  WIDTH  slots allowed to retire this cycle (combinational).
- mispredict  out  1  registered one-cycle redirect pulse.
- mispredict_target_pc  out  XLEN  registered redirect PC.
- mispredict_slot  out  $clog2(WIDTH)  registered slot index of the mispredicting branch (width 1 when WIDTH=1).
- flush_busy  out  1  recovery window active.
- br_count  out  CNT_W  retired branches, saturating.
- misp_count  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset values: all registered outputs are 0, counters are 0, FSM is IDLE.
- Eligibility:
  - eligible[i] = &retire_rdy[i:0] (contiguous-ready prefix).
  - Never eligible while FSM is FLUSH.
- Per-slot mispredict: misp[i] = is_branch[i] & ((ex_take[i] != pred_take[i]) | (ex_take[i] & pred_take[i] & (ex_target[i] != pred_target[i]))).
- Detection:
  - k = lowest index with eligible[k] & misp[k]. Only k matters; younger mispredicts are ignored.
  - Because of the prefix rule, an unready slot j blocks every slot above j.
- retire_en is combinational, same cycle:
  - With a detection: eligible slots 0..k, inclusive of the branch.
  - Otherwise: all eligible slots.
  - In FLUSH: 0.
- FSM states IDLE and FLUSH:
  - IDLE -> FLUSH on detection at edge t. At t+1: mispredict=1, mispredict_target_pc = ex_target[k], mispredict_slot = k, flush_busy=1, cnt = FLUSH_CYCLES-1.
  - FLUSH: mispredict=0 after its first cycle; target and slot hold their values. If cnt==0, go to IDLE at the next edge; otherwise decrement cnt.
  - flush_busy is high for exactly FLUSH_CYCLES cycles. Detection can occur again on the first IDLE cycle.
- Not-taken mispredict: the redirect target is ex_target[k]. The execute stage supplies the fall-through PC there.
- Counters:
  - br_count += popcount(retire_en & is_branch).
  - misp_count += 1 per detection.
  - Both saturate at 2^CNT_W-1; the sum must not wrap.
  - stat_clear has priority over the same-cycle increment and zeroes both counters.
- Reset asserted mid-FLUSH: immediately returns to IDLE and clears outputs and counters.
- Inputs are ignored while reset is low.

Test Plan:
- WIDTH=2, reset low, then high:
  - All outputs are 0.
  - Slot0 branch ready with ex_take=1, pred_take=1, equal targets 0x100 -> retire_en=2'b01 (slot1 not ready), no mispredict, br_count=1.
- WIDTH=2, both slots ready:
  - Slot0 non-branch; slot1 branch with ex_take=1, pred_take=0, ex_target=0x2040.
  - Same cycle: retire_en=2'b11.
  - Next cycle: mispredict=1, target=0x2040, slot=1, flush_busy high for 2 cycles, misp_count=1.
- WIDTH=4, all ready:
  - Slot1 mispredicts on a target mismatch (0x80 vs 0x84); slot3 also mispredicts.
  - retire_en=4'b0011, target=0x80, slot=1, misp_count=1.
  - During FLUSH, retire_en=0 despite ready inputs.
- WIDTH=2:
  - Slot0 not ready and slot1 a ready mispredicting branch -> retire_en=0, no detection.
  - Then slot0 becomes ready -> detection on slot1.
- CNT_W=4:
  - Preload br_count to 14, then retire two branches -> br_count=15 (saturated).
  - stat_clear together with a detection -> both counters 0 on the next cycle.
- Assert reset during the second FLUSH cycle -> flush_busy=0 and mispredict=0 immediately; after release, detection works on the first cycle.

Source files
------------

// File: rtl/br_retire_resolve.sv
// br_retire_resolve
//   Retire-stage branch resolver. It scans the WIDTH oldest ROB entries
//   (slot 0 is the oldest) and looks for the oldest retire-ready branch whose
//   executed outcome differs from its prediction. On a hit, retirement is cut
//   off after that branch. One registered redirect pulse is then issued, and a
//   flush window of FLUSH_CYCLES cycles blocks retirement while fetch/rename
//   recover. The block also keeps saturating counts of retired branches and
//   of mispredicts.
//
// Ports
//   clock                 rising-edge clock
//   reset                 asynchronous active-low reset
//   retire_rdy[WIDTH]     per-slot ROB entry complete
//   is_branch[WIDTH]      slot holds a branch
//   ex_take / pred_take   executed / predicted direction per slot
//   ex_target/pred_target executed / predicted target, slot i at [i*XLEN +: XLEN]
//   stat_clear            synchronous clear of both counters (beats increment)
//   retire_en[WIDTH]      combinational retire permission per slot
//   mispredict            registered one-cycle redirect pulse
//   mispredict_target_pc  registered redirect PC (held through the flush)
//   mispredict_slot       registered slot index of the mispredicting branch
//   flush_busy            recovery window active
//   br_count, misp_count  saturating statistics counters
module br_retire_resolve #(
  parameter int WIDTH        = 2,
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32,
  localparam int SLOT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      retire_rdy,
  input  logic [WIDTH-1:0]      is_branch,
  input  logic [WIDTH-1:0]      ex_take,
  input  logic [WIDTH-1:0]      pred_take,
  input  logic [WIDTH*XLEN-1:0] ex_target,
  input  logic [WIDTH*XLEN-1:0] pred_target,
  input  logic                  stat_clear,
  output logic [WIDTH-1:0]      retire_en,
  output logic                  mispredict,
  output logic [XLEN-1:0]       mispredict_target_pc,
  output logic [SLOT_W-1:0]     mispredict_slot,
  output logic                  flush_busy,
  output logic [CNT_W-1:0]      br_count,
  output logic [CNT_W-1:0]      misp_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // Four spare bits absorb a popcount of up to 8 before the saturation test.
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = {4'b0000, {CNT_W{1'b1}}};

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic                misp_q, misp_d;
  logic [XLEN-1:0]     tgt_q, tgt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]    misp_cnt_q, misp_cnt_d;

  logic                in_flush;
  logic [WIDTH-1:0]    slot_misp;
  logic                detect;
  logic [SLOT_W-1:0]   det_slot;
  logic [XLEN-1:0]     det_tgt;
  logic [3:0]          br_inc;
  logic [SUM_W-1:0]    br_sum;

  // Per-slot mispredict: wrong direction, or taken-both with a wrong target.
  always_comb begin
    slot_misp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      slot_misp[i] = is_branch[i] &
                     ((ex_take[i] != pred_take[i]) |
                      (ex_take[i] & pred_take[i] &
                       (ex_target[i*XLEN +: XLEN] != pred_target[i*XLEN +: XLEN])));
    end
  end

  // Oldest-first scan. The running AND gives the contiguous-ready prefix, so an
  // unready slot blocks everything younger. Once the oldest eligible
  // mispredict is found, younger slots lose retire permission and any younger
  // mispredicts are ignored.
  always_comb begin
    logic run_rdy;
    logic elig;
    run_rdy   = 1'b1;
    detect    = 1'b0;
    det_slot  = '0;
    det_tgt   = '0;
    retire_en = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run_rdy      = run_rdy & retire_rdy[i];
      elig         = run_rdy & ~in_flush;
      retire_en[i] = elig & ~detect;
      if (elig && slot_misp[i] && !detect) begin
        detect   = 1'b1;
        det_slot = SLOT_W'(i);
        det_tgt  = ex_target[i*XLEN +: XLEN];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // FSM next state. The flush counter is loaded with FLUSH_CYCLES-1 on entry,
  // so flush_busy stays high for exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (detect) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_flush   = (state_q == FLUSH);
    flush_busy = in_flush;
  end

  // Redirect pulse and captured target/slot, which hold until the next detection.
  always_comb begin
    misp_d = detect;
    tgt_d  = detect ? det_tgt  : tgt_q;
    slot_d = detect ? det_slot : slot_q;
  end

  // Saturating statistics; stat_clear wins over a same-cycle increment.
  always_comb begin
    br_inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      br_inc = br_inc + 4'(retire_en[i] & is_branch[i]);
    end
    br_sum = {4'b0000, br_cnt_q} + {{CNT_W{1'b0}}, br_inc};

    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (stat_clear) begin
      br_cnt_d   = '0;
      misp_cnt_d = '0;
    end else begin
      br_cnt_d = (br_sum > CNT_MAX) ? {CNT_W{1'b1}} : br_sum[CNT_W-1:0];
      if (detect && (misp_cnt_q != {CNT_W{1'b1}})) misp_cnt_d = misp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misp_q     <= 1'b0;
      tgt_q      <= '0;
      slot_q     <= '0;
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      misp_q     <= misp_d;
      tgt_q      <= tgt_d;
      slot_q     <= slot_d;
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign mispredict           = misp_q;
  assign mispredict_target_pc = tgt_q;
  assign mispredict_slot      = slot_q;
  assign br_count             = br_cnt_q;
  assign misp_count           = misp_cnt_q;

endmodule

// File: tb/tb_br_retire_resolve.sv
// Directed bench for br_retire_resolve. Two instances share clock and reset:
// a WIDTH=2 / CNT_W=4 instance (u2) and a WIDTH=4 / CNT_W=32 instance (u4).
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// in the same window, before the next edge.
module tb_br_retire_resolve;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // WIDTH=2, CNT_W=4 instance
  logic [1:0]  rdy2, br2, ext2, prt2, ren2;
  logic [63:0] ext_tgt2, prd_tgt2;
  logic        clr2, misp2, busy2;
  logic [31:0] mtgt2;
  logic [0:0]  mslot2;
  logic [3:0]  brc2, mpc2;

  // WIDTH=4, CNT_W=32 instance
  logic [3:0]   rdy4, br4, ext4, prt4, ren4;
  logic [127:0] ext_tgt4, prd_tgt4;
  logic         clr4, misp4, busy4;
  logic [31:0]  mtgt4;
  logic [1:0]   mslot4;
  logic [31:0]  brc4, mpc4;

  br_retire_resolve #(.WIDTH(2), .XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) u2 (
    .clock(clock), .reset(reset),
    .retire_rdy(rdy2), .is_branch(br2), .ex_take(ext2), .pred_take(prt2),
    .ex_target(ext_tgt2), .pred_target(prd_tgt2), .stat_clear(clr2),
    .retire_en(ren2), .mispredict(misp2), .mispredict_target_pc(mtgt2),
    .mispredict_slot(mslot2), .flush_busy(busy2),
    .br_count(brc2), .misp_count(mpc2)
  );

  br_retire_resolve #(.WIDTH(4), .XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) u4 (
    .clock(clock), .reset(reset),
    .retire_rdy(rdy4), .is_branch(br4), .ex_take(ext4), .pred_take(prt4),
    .ex_target(ext_tgt4), .pred_target(prd_tgt4), .stat_clear(clr4),
    .retire_en(ren4), .mispredict(misp4), .mispredict_target_pc(mtgt4),
    .mispredict_slot(mslot4), .flush_busy(busy4),
    .br_count(brc4), .misp_count(mpc4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle2();
    rdy2 = '0; br2 = '0; ext2 = '0; prt2 = '0;
    ext_tgt2 = '0; prd_tgt2 = '0; clr2 = 1'b0;
  endtask

  task automatic idle4();
    rdy4 = '0; br4 = '0; ext4 = '0; prt4 = '0;
    ext_tgt4 = '0; prd_tgt4 = '0; clr4 = 1'b0;
  endtask

  initial begin
    idle2();
    idle4();

    // Reset held low: everything quiet.
    step();
    step();
    chk("rst_misp", misp2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_tgt", mtgt2, 0);
    chk("rst_brc", brc2, 0);
    chk("rst_mpc", mpc2, 0);
    chk("rst_ren", ren2, 0);
    reset = 1'b1;
    step();
    chk("post_rst_busy", busy2, 0);

    // Correctly predicted taken branch in slot 0, slot 1 not ready.
    rdy2 = 2'b01; br2 = 2'b01; ext2 = 2'b01; prt2 = 2'b01;
    ext_tgt2[31:0] = 32'h100; prd_tgt2[31:0] = 32'h100;
    #1;
    chk("t1_ren", ren2, 2'b01);
    step();
    chk("t1_misp", misp2, 0);
    chk("t1_brc", brc2, 1);
    chk("t1_busy", busy2, 0);
    idle2();

    // Slot 1 direction mispredict behind a non-branch.
    rdy2 = 2'b11; br2 = 2'b10; ext2 = 2'b10; prt2 = 2'b00;
    ext_tgt2[63:32] = 32'h2040;
    #1;
    chk("t2_ren", ren2, 2'b11);
    step();
    chk("t2_misp", misp2, 1);
    chk("t2_tgt", mtgt2, 32'h2040);
    chk("t2_slot", mslot2, 1);
    chk("t2_busy1", busy2, 1);
    chk("t2_mpc", mpc2, 1);
    chk("t2_brc", brc2, 2);
    chk("t2_ren_flush", ren2, 0);
    step();
    chk("t2_misp_off", misp2, 0);
    chk("t2_busy2", busy2, 1);
    chk("t2_tgt_hold", mtgt2, 32'h2040);
    idle2();
    step();
    chk("t2_busy_end", busy2, 0);
    chk("t2_brc_hold", brc2, 2);

    // Unready slot 0 blocks the mispredicting slot 1 until it becomes ready.
    rdy2 = 2'b10; br2 = 2'b10; ext2 = 2'b10; prt2 = 2'b00;
    ext_tgt2[63:32] = 32'h3000;
    #1;
    chk("t4_ren_block", ren2, 2'b00);
    step();
    chk("t4_no_misp", misp2, 0);
    chk("t4_no_busy", busy2, 0);
    rdy2 = 2'b11;
    #1;
    chk("t4_ren", ren2, 2'b11);
    step();
    chk("t4_misp", misp2, 1);
    chk("t4_tgt", mtgt2, 32'h3000);
    chk("t4_mpc", mpc2, 2);
    chk("t4_brc", brc2, 3);
    idle2();
    step();
    step();
    chk("t4_idle", busy2, 0);

    // Saturation of the 4-bit branch counter: 3 -> 4 -> 14 -> 15 (sticky).
    rdy2 = 2'b01; br2 = 2'b01;
    step();
    chk("sat_4", brc2, 4);
    rdy2 = 2'b11; br2 = 2'b11;
    for (int i = 0; i < 5; i++) step();
    chk("sat_14", brc2, 14);
    step();
    chk("sat_15", brc2, 15);
    step();
    chk("sat_hold", brc2, 15);
    chk("sat_no_misp", misp2, 0);

    // WIDTH=4: slot 1 target mismatch is oldest; slot 3 also mispredicts.
    rdy4 = 4'b1111; br4 = 4'b1010; ext4 = 4'b1010; prt4 = 4'b0010;
    ext_tgt4[63:32] = 32'h80; prd_tgt4[63:32] = 32'h84;
    ext_tgt4[127:96] = 32'hDEAD0;
    #1;
    chk("w4_ren", ren4, 4'b0011);
    step();
    chk("w4_misp", misp4, 1);
    chk("w4_tgt", mtgt4, 32'h80);
    chk("w4_slot", mslot4, 1);
    chk("w4_mpc", mpc4, 1);
    chk("w4_brc", brc4, 1);
    chk("w4_ren_flush", ren4, 0);
    chk("w4_busy", busy4, 1);
    idle4();

    // stat_clear together with a detection on slot 0 (not-taken mispredict).
    rdy2 = 2'b11; br2 = 2'b01; ext2 = 2'b01; prt2 = 2'b00;
    ext_tgt2 = '0; ext_tgt2[31:0] = 32'h4444; clr2 = 1'b1;
    #1;
    chk("clr_ren", ren2, 2'b01);
    step();
    chk("clr_misp", misp2, 1);
    chk("clr_tgt", mtgt2, 32'h4444);
    chk("clr_slot", mslot2, 0);
    chk("clr_brc", brc2, 0);
    chk("clr_mpc", mpc2, 0);
    idle2();

    // Reset in the second flush cycle.
    step();
    chk("mid_busy", busy2, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy2, 0);
    chk("arst_misp", misp2, 0);
    chk("arst_tgt", mtgt2, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Detection on the very first cycle after release.
    rdy2 = 2'b01; br2 = 2'b01; ext2 = 2'b00; prt2 = 2'b01;
    ext_tgt2[31:0] = 32'h55C;
    #1;
    chk("rel_ren", ren2, 2'b01);
    step();
    chk("rel_misp", misp2, 1);
    chk("rel_tgt", mtgt2, 32'h55C);
    chk("rel_mpc", mpc2, 1);
    chk("rel_brc", brc2, 1);
    idle2();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
